// File: rtl/cu_exec_sequencer.sv
// cu_exec_sequencer: multi-cycle read/ALU/write-back sequencer driven by control-unit strobes
module cu_exec_sequencer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [3:0]        opcode,
  input  logic              cu_ram_read,
  input  logic              cu_ram_write,
  input  logic              cu_alu_enable,
  input  logic [3:0]        cu_alu_op,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  output logic              mem_wr_en,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  output logic              busy,
  output logic              done,
  output logic              err
);
  typedef enum logic [3:0] {
    S_IDLE, S_DECODE, S_RD_A, S_RD_B, S_RD_IND, S_CAPTURE, S_EXEC, S_WRITE, S_DONE
  } state_t;
  state_t            r_state, w_next;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_op_a, r_op_b, r_result;
  logic              r_alu_en, r_err;
  logic [3:0]        r_alu_op;
  logic [ADDR_W-1:0] w_dst, w_src_a, w_src_b;
  logic              w_illegal, w_mvi;
  assign w_dst     = ADDR_W'(r_ir[11:8]);
  assign w_src_a   = ADDR_W'(r_ir[7:4]);
  assign w_src_b   = ADDR_W'(r_ir[3:0]);
  assign w_illegal = !cu_ram_read && !cu_ram_write;
  assign w_mvi     = cu_ram_write && !cu_ram_read;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_ir     <= '0;
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_result <= '0;
      r_alu_en <= 1'b0;
      r_alu_op <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (instr_valid) r_ir <= instr;
        S_DECODE: begin
          r_alu_en <= cu_alu_enable;
          r_alu_op <= cu_alu_op;
          r_err    <= w_illegal;
          if (w_mvi) r_result <= DATA_W'(r_ir[7:0]);
        end
        S_RD_B, S_RD_IND: r_op_a <= mem_rdata;
        S_CAPTURE: if (r_alu_en) r_op_b <= mem_rdata; else r_result <= mem_rdata;
        S_EXEC: r_result <= alu_result;
        default: ;
      endcase
    end
  end
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    w_next = instr_valid ? S_DECODE : S_IDLE;
      S_DECODE:  w_next = w_illegal ? S_DONE : w_mvi ? S_WRITE : S_RD_A;
      S_RD_A:    w_next = r_alu_en ? S_RD_B : (r_ir[15:12] == 4'hD) ? S_RD_IND : S_CAPTURE;
      S_RD_B,
      S_RD_IND:  w_next = S_CAPTURE;
      S_CAPTURE: w_next = r_alu_en ? S_EXEC : S_WRITE;
      S_EXEC:    w_next = S_WRITE;
      S_WRITE:   w_next = S_DONE;
      default:   w_next = S_IDLE;
    endcase
  end
  assign instr_ready = r_state == S_IDLE;
  assign busy        = r_state != S_IDLE;
  assign opcode      = r_ir[15:12];
  assign mem_rd_en   = r_state inside {S_RD_A, S_RD_B, S_RD_IND};
  assign mem_wr_en   = r_state == S_WRITE;
  // the indirect pointer comes straight from the RAM output register
  assign mem_addr    = (r_state == S_RD_A)   ? w_src_a :
                       (r_state == S_RD_B)   ? w_src_b :
                       (r_state == S_RD_IND) ? mem_rdata[ADDR_W-1:0] :
                       (r_state == S_WRITE)  ? w_dst : '0;
  assign mem_wdata   = (r_state == S_WRITE) ? r_result : '0;
  assign alu_a       = (r_state == S_EXEC) ? r_op_a : '0;
  assign alu_b       = (r_state == S_EXEC) ? r_op_b : '0;
  assign alu_op      = (r_state == S_EXEC) ? r_alu_op : '0;
  assign done        = r_state == S_DONE;
  assign err         = (r_state == S_DONE) && r_err;
endmodule

// File: doc/cu_exec_sequencer.md
Name: cu_exec_sequencer

Overview:
- Multi-cycle execution sequencer; the consumer end of the control unit's decode interface.
- Accepts 16-bit instructions over a valid/ready handshake and drives the opcode to the control unit.
- Samples the returned strobes (ram_read, ram_write, alu_enable, alu_op), then runs the read / ALU / write-back sequence against a single-port synchronous RAM and a combinational ALU.
- Sits between the instruction source and the CU/RAM/ALU datapath.

Parameters:
- DATA_W, 8: RAM word and ALU operand width.
- ADDR_W, 4: RAM address width. Instruction address fields are 4 bits and are zero-extended to ADDR_W.

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr  in  16  instruction: [15:12] opcode, [11:8] dst, [7:4] srcA, [3:0] srcB, [7:0] imm (MVI)
- instr_valid  in  1  instruction offered
- instr_ready  out  1  high only in IDLE
- opcode  out  4  to CU; always equals latched IR[15:12]
- cu_ram_read  in  1  from CU
- cu_ram_write  in  1  from CU
- cu_alu_enable  in  1  from CU
- cu_alu_op  in  4  from CU
- mem_addr  out  ADDR_W  RAM address
- mem_rd_en  out  1  RAM read strobe; data valid on mem_rdata the following cycle
- mem_wr_en  out  1  RAM write strobe
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data
- alu_a, alu_b  out  DATA_W  ALU operands
- alu_op  out  4  latched cu_alu_op; 0 outside EXEC
- alu_result  in  DATA_W  combinational ALU result
- busy  out  1  high whenever state is not IDLE
- done  out  1  one-cycle pulse at instruction completion
- err  out  1  one-cycle pulse with done for an undecoded opcode

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE; IR, opA, opB, result and latched strobes cleared to 0.
  - Outputs: opcode=0, mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0, alu_a=0, alu_b=0, alu_op=0, done=0, err=0, busy=0, instr_ready=1.
  - Reset mid-instruction aborts immediately. No write is issued after rst_n falls, and no partial write-back occurs.
- All outputs are decoded from registered state and registers; there is no combinational path from instr to any output.
- States:
  - IDLE: instr_ready=1. On instr_valid & instr_ready at an edge, IR<=instr and go to DECODE. instr_valid at any other time is ignored.
  - DECODE: latch the CU strobes and go to:
    - DONE with err=1 if cu_ram_read=0 and cu_ram_write=0 (opcodes 0, 14, 15). No memory access.
    - WRITE with result<=imm[DATA_W-1:0] (zero-extended if DATA_W>8) if cu_ram_write=1 and cu_ram_read=0 (MVI).
    - RD_A otherwise.
  - RD_A: rd_en=1, addr=srcA. Next: RD_B if alu_enable; RD_IND if opcode=4'b1101 (LDA); otherwise CAPTURE (MOV).
  - RD_B: opA<=mem_rdata; rd_en=1, addr=srcB; go to CAPTURE.
  - RD_IND: opA<=mem_rdata; rd_en=1, addr=mem_rdata[ADDR_W-1:0]; go to CAPTURE.
  - CAPTURE: if alu_enable, opB<=mem_rdata and go to EXEC. Otherwise result<=mem_rdata and go to WRITE.
  - EXEC: alu_a=opA, alu_b=opB, alu_op=latched op; result<=alu_result; go to WRITE. srcB is always read for ALU ops; the ALU ignores alu_b for NOT.
  - WRITE: wr_en=1, addr=dst, wdata=result; go to DONE.
  - DONE: done=1 (and err=1 if flagged); go to IDLE.
- Latency (acceptance edge = T, done high in cycle):
  - illegal: T+2
  - MVI: T+3
  - MOV: T+5
  - LDA: T+6
  - ALU ops: T+7
- Exactly one mem_wr_en pulse per legal instruction; none for an illegal one.
- Exactly one rd_en per RD_* cycle; rd_en and wr_en are never high together.
- src==dst is legal: the read completes before the write.
- LDA indirect pointer uses the low ADDR_W bits of the fetched word; upper bits are ignored.
- Back-to-back: the earliest next acceptance is the cycle after DONE (IDLE), so at least one idle cycle separates instructions.
- ALU arithmetic wraps modulo 2^DATA_W. No flags are kept by this block.

Test Plan:
- MVI: RAM cleared, instr=16'hC3A5 -> DONE at T+3; single write addr=3 data=8'hA5; no rd_en pulses.
- ADD: mem[1]=8'hF0, mem[2]=8'h20, instr=16'h2512, ALU model adds -> alu_op=4'b0001 in EXEC; write addr=5 data=8'h10 (wrap); done at T+7.
- LDA: mem[4]=8'h09, mem[9]=8'h5C, instr=16'hD640 -> reads addr 4 then addr 9; write addr=6 data=8'h5C; done at T+6.
- Illegal opcode: instr=16'hE123, then 16'h0000 -> done and err together at T+2; no mem_rd_en or mem_wr_en; instr_ready back high at T+3.
- Reset mid-op: ADD accepted, rst_n pulled low during RD_B -> outputs immediately at reset values, no write to dst; after release, MOV mem[7]->mem[8] completes correctly.
- Handshake: instr_valid held high with 3 queued MOVs -> each accepted only when instr_ready=1; busy high throughout each; three done pulses spaced 6 cycles apart.
